// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed scan controller for a common-segment multi-digit 7-segment
// display. It presents one nibble at a time to a shared hex-to-segment decoder
// and drives one-hot digit enables. Every digit is preceded by a blanking gap,
// which keeps the previous digit's segments from ghosting onto the next digit.
// The displayed value is double-buffered, so a frame never shows a mix of old
// and new digits.
//
// Ports:
//   clk         system clock; all state changes happen on its rising edge
//   rst_n       asynchronous active-low reset
//   ena         scan enable; when low the display goes dark (IDLE)
//   load        single-cycle strobe that captures data_in / dp_in
//   data_in     hex value; digit k is data_in[4k+3:4k]
//   dp_in       decimal point per digit, captured together with data_in
//   blank_lz    leading-zero suppression enable, sampled live
//   nibble_out  nibble for the current digit, sent to the decoder
//   dp_out      decimal point for the current digit
//   digit_en    one-hot active-high digit select
//   frame_done  one-cycle pulse on the first BLANK cycle of each new frame
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [3:0]              nibble_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int MAXC = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [IW-1:0]           idx_reg, idx_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] act_data_reg, act_data_next;
  logic [NUM_DIGITS-1:0]   act_dp_reg, act_dp_next;
  logic [4*NUM_DIGITS-1:0] pend_data_reg, pend_data_next;
  logic [NUM_DIGITS-1:0]   pend_dp_reg, pend_dp_next;
  logic                    pend_flag_reg, pend_flag_next;

  logic [3:0]              nib_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   hi_zero;
  logic [3:0]              nibble_next;
  logic                    dp_next;
  logic                    suppress;
  logic [NUM_DIGITS-1:0]   digit_en_next;

  // Scan sequencer: IDLE -> (BLANK -> SHOW) per digit, wrapping at the last digit.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    wrap       = 1'b0;
    if (!ena) begin
      state_next = IDLE;
      idx_next   = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = BLANK;
          idx_next   = '0;
          cnt_next   = '0;
        end
        BLANK: begin
          if (cnt_reg == BLANK_LAST) begin
            state_next = SHOW;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        SHOW: begin
          if (cnt_reg == SHOW_LAST) begin
            state_next = BLANK;
            cnt_next   = '0;
            if (idx_reg == IDX_LAST) begin
              idx_next = '0;
              wrap     = 1'b1;
            end else begin
              idx_next = idx_reg + IW'(1);
            end
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = '0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Double buffer. The commit is taken while frame_done is high, which is the
  // first BLANK cycle of digit 0, so the swap never lands mid-frame. A load in
  // that same cycle wins over whatever was pending.
  always_comb begin
    act_data_next  = act_data_reg;
    act_dp_next    = act_dp_reg;
    pend_data_next = pend_data_reg;
    pend_dp_next   = pend_dp_reg;
    pend_flag_next = pend_flag_reg;
    if (frame_done) begin
      if (load) begin
        act_data_next = data_in;
        act_dp_next   = dp_in;
      end else if (pend_flag_reg) begin
        act_data_next = pend_data_reg;
        act_dp_next   = pend_dp_reg;
      end
      pend_flag_next = 1'b0;
    end else if (load) begin
      if (state_reg == IDLE) begin
        act_data_next = data_in;
        act_dp_next   = dp_in;
      end else begin
        pend_data_next = data_in;
        pend_dp_next   = dp_in;
        pend_flag_next = 1'b1;
      end
    end
  end

  // Per-digit nibble view, plus a flag saying "this digit and every digit
  // above it are zero". Both are taken from the post-update active buffer.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib_arr[gi] = act_data_next[4*gi +: 4];
      assign hi_zero[gi] = (act_data_next[4*NUM_DIGITS-1:4*gi] == '0);
    end
  endgenerate

  // The outputs are computed from the next state, so the registered outputs
  // line up with the state they describe. nibble_out follows the digit
  // through BLANK as well, which gives the decoder time to settle before the
  // enable is driven.
  always_comb begin
    nibble_next   = nib_arr[idx_next];
    dp_next       = act_dp_next[idx_next];
    suppress      = blank_lz && (idx_next != '0) && hi_zero[idx_next];
    digit_en_next = '0;
    if ((state_next == SHOW) && !suppress) begin
      digit_en_next = NUM_DIGITS'(1) << idx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      act_data_reg  <= '0;
      act_dp_reg    <= '0;
      pend_data_reg <= '0;
      pend_dp_reg   <= '0;
      pend_flag_reg <= 1'b0;
      nibble_out    <= '0;
      dp_out        <= 1'b0;
      digit_en      <= '0;
      frame_done    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      cnt_reg       <= cnt_next;
      act_data_reg  <= act_data_next;
      act_dp_reg    <= act_dp_next;
      pend_data_reg <= pend_data_next;
      pend_dp_reg   <= pend_dp_next;
      pend_flag_reg <= pend_flag_next;
      nibble_out    <= nibble_next;
      dp_out        <= dp_next;
      digit_en      <= digit_en_next;
      frame_done    <= wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
// Self-checking bench for seg7_scan_ctrl with NUM_DIGITS=4, PRESCALE=4 and
// BLANK_CYCLES=2. A reference model derives the expected outputs from the
// elapsed scan time: digit = t / slot, phase = t % slot. Inputs are driven on
// the falling edge and outputs are compared on the falling edge.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int P     = 4;
  localparam int B     = 2;
  localparam int SLOT  = B + P;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  nibble_out;
  logic        dp_out;
  logic [3:0]  digit_en;
  logic        frame_done;
  logic [9:0]  obs;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit          m_en;
  int          m_t;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_adp, m_pdp;
  bit          m_pflag, m_fd;
  logic [3:0]  e_nib, e_en;
  logic        e_dp;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load(load), .data_in(data_in),
    .dp_in(dp_in), .blank_lz(blank_lz), .nibble_out(nibble_out),
    .dp_out(dp_out), .digit_en(digit_en), .frame_done(frame_done)
  );

  assign obs = {nibble_out, dp_out, digit_en, frame_done};

  always #5 clk = ~clk;

  task automatic model_step();
    int d, w;
    logic [15:0] hi;
    if (!rst_n) begin
      m_en = 0; m_t = 0; m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0;
      m_pflag = 0; m_fd = 0; e_nib = '0; e_en = '0; e_dp = 1'b0;
      return;
    end
    // Buffer rules: the swap happens in the frame_done cycle; a load in that
    // cycle goes straight to active; a load while idle goes straight to
    // active; any other load goes to pending.
    if (m_fd) begin
      if (load) begin m_act = data_in; m_adp = dp_in; end
      else if (m_pflag) begin m_act = m_pend; m_adp = m_pdp; end
      m_pflag = 0;
    end else if (load) begin
      if (!m_en) begin m_act = data_in; m_adp = dp_in; end
      else begin m_pend = data_in; m_pdp = dp_in; m_pflag = 1; end
    end
    // Timing: t counts clocks since the first BLANK cycle of digit 0.
    if (!ena) begin
      m_en = 0; m_t = 0; m_fd = 0;
    end else if (!m_en) begin
      m_en = 1; m_t = 0; m_fd = 0;
    end else begin
      m_t++;
      m_fd = ((m_t % FRAME) == 0);
    end
    d = m_en ? (m_t / SLOT) % ND : 0;
    w = m_en ? (m_t % SLOT) : 0;
    e_nib = m_act[4*d +: 4];
    e_dp  = m_adp[d];
    hi    = m_act >> (4 * d);
    e_en  = (m_en && (w >= B) && !(blank_lz && (d > 0) && (hi == 16'h0))) ? (4'b0001 << d) : 4'b0000;
  endtask

  function automatic logic [9:0] exp_vec();
    return {e_nib, e_dp, e_en, m_fd};
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Reset the design, load a value while idle, then enable. The next falling
  // edge after this returns shows t=0, the first BLANK cycle of digit 0.
  task automatic restart(input logic [15:0] d, input logic [3:0] p);
    @(negedge clk); rst_n = 0; ena = 0; load = 0;
    @(negedge clk); rst_n = 1; load = 1; data_in = d; dp_in = p;
    @(negedge clk); load = 0; ena = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; ena = 1; load = 1; data_in = 16'hBEEF; dp_in = 4'hF; blank_lz = 0;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (obs !== 10'b0) begin fails++; $display("FAIL reset_hold: got %h expected %h", obs, 10'b0); end
    end
    rst_n = 1; ena = 0; load = 0;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (obs !== 10'b0) begin fails++; $display("FAIL reset_release: got %h expected %h", obs, 10'b0); end
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL reset_model: got %h expected %h", obs, exp_vec()); end
    end
    ena = 1;
    repeat (3) @(negedge clk);
    tests++;
    if (digit_en !== 4'b0001) begin fails++; $display("FAIL reset_preshow: got %b expected %b", digit_en, 4'b0001); end
    rst_n = 0;
    #1;
    tests++;
    if (obs !== 10'b0) begin fails++; $display("FAIL reset_async: got %h expected %h", obs, 10'b0); end
    @(negedge clk);
    rst_n = 1; ena = 0;
  endtask

  task automatic test_basic_scan();
    int fd_first = -1;
    int fd_second = -1;
    blank_lz = 0;
    restart(16'h1234, 4'b0100);
    for (int c = 0; c < 56; c++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL basic_scan t=%0d: got %h expected %h", c, obs, exp_vec()); end
      if (c == 0 || c == 2 || c == 14 || c == 20) begin
        logic [8:0] want;
        case (c)
          0:       want = {4'h4, 1'b0, 4'b0000};
          2:       want = {4'h4, 1'b0, 4'b0001};
          14:      want = {4'h2, 1'b1, 4'b0100};
          default: want = {4'h1, 1'b0, 4'b1000};
        endcase
        tests++;
        if (obs[9:1] !== want) begin fails++; $display("FAIL basic_digit t=%0d: got %h expected %h", c, obs[9:1], want); end
      end
      if (frame_done === 1'b1) begin
        if (fd_first < 0) fd_first = c;
        else if (fd_second < 0) fd_second = c;
      end
    end
    tests++;
    if (fd_first != FRAME) begin fails++; $display("FAIL basic_frame_first: got %0d expected %0d", fd_first, FRAME); end
    tests++;
    if (fd_second - fd_first != FRAME) begin fails++; $display("FAIL basic_frame_period: got %0d expected %0d", fd_second - fd_first, FRAME); end
  endtask

  task automatic test_double_buffer();
    blank_lz = 0;
    restart(16'h1234, 4'b0000);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL double_buffer t=%0d: got %h expected %h", c, obs, exp_vec()); end
      if (c == 16 || c == 22 || c == 26 || c == 32 || c == 38 || c == 44) begin
        logic [3:0] want;
        case (c)
          16: want = 4'h2;
          22: want = 4'h1;
          26: want = 4'hD;
          32: want = 4'hC;
          38: want = 4'hB;
          default: want = 4'hA;
        endcase
        tests++;
        if (nibble_out !== want) begin fails++; $display("FAIL double_buffer_nib t=%0d: got %h expected %h", c, nibble_out, want); end
      end
      if (c == FRAME) begin
        tests++;
        if (frame_done !== 1'b1) begin fails++; $display("FAIL double_buffer_fd: got %b expected 1", frame_done); end
      end
      load = 0;
      if (c == 8) begin load = 1; data_in = 16'hABCD; end
    end
    load = 0;
  endtask

  task automatic test_load_boundary();
    blank_lz = 0;
    restart(16'h1234, 4'b0000);
    for (int c = 0; c < 76; c++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL load_boundary t=%0d: got %h expected %h", c, obs, exp_vec()); end
      if (c == FRAME) begin
        tests++;
        if ({frame_done, nibble_out} !== {1'b1, 4'h4}) begin fails++; $display("FAIL boundary_cycle: got %h expected %h", {frame_done, nibble_out}, {1'b1, 4'h4}); end
      end
      if (c >= 26 && (c % SLOT) == 2) begin
        tests++;
        if (nibble_out !== 4'h5) begin fails++; $display("FAIL boundary_nib t=%0d: got %h expected %h", c, nibble_out, 4'h5); end
      end
      load = 0;
      if (c == 5) begin load = 1; data_in = 16'h9999; end
      if (c == FRAME) begin load = 1; data_in = 16'h5555; end
    end
    load = 0;
  endtask

  task automatic test_leading_zeros();
    logic [15:0] vals [3] = '{16'h0050, 16'h0000, 16'h0000};
    bit          lzs  [3] = '{1'b1, 1'b1, 1'b0};
    int          need [3][4] = '{'{4, 4, 0, 0}, '{4, 0, 0, 0}, '{4, 4, 4, 4}};
    int          lit  [4];
    for (int s = 0; s < 3; s++) begin
      blank_lz = lzs[s];
      restart(vals[s], 4'b0000);
      for (int k = 0; k < 4; k++) lit[k] = 0;
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        tests++;
        if (obs !== exp_vec()) begin fails++; $display("FAIL leading_zeros s=%0d t=%0d: got %h expected %h", s, c, obs, exp_vec()); end
        for (int k = 0; k < 4; k++) lit[k] += int'(digit_en[k]);
      end
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (lit[k] != need[s][k]) begin fails++; $display("FAIL lz_lit s=%0d digit=%0d: got %0d expected %0d", s, k, lit[k], need[s][k]); end
      end
    end
    blank_lz = 0;
  endtask

  task automatic test_enable_drop();
    blank_lz = 0;
    restart(16'h1234, 4'b0000);
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL enable_run t=%0d: got %h expected %h", c, obs, exp_vec()); end
    end
    tests++;
    if (digit_en !== 4'b0100) begin fails++; $display("FAIL enable_pre_drop: got %b expected %b", digit_en, 4'b0100); end
    ena = 0;
    @(negedge clk);
    tests++;
    if ({digit_en, frame_done} !== 5'b0) begin fails++; $display("FAIL enable_drop: got %b expected %b", {digit_en, frame_done}, 5'b0); end
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL enable_idle: got %h expected %h", obs, exp_vec()); end
    end
    ena = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL enable_restart t=%0d: got %h expected %h", c, obs, exp_vec()); end
      if (c == 0 || c == 2 || c == FRAME) begin
        logic [5:0] want;
        case (c)
          0:       want = {4'h4, 1'b0, 1'b0};
          2:       want = {4'h4, 1'b1, 1'b0};
          default: want = {4'h4, 1'b0, 1'b1};
        endcase
        tests++;
        if ({nibble_out, digit_en[0], frame_done} !== want) begin
          fails++; $display("FAIL enable_restart_pt t=%0d: got %b expected %b", c, {nibble_out, digit_en[0], frame_done}, want);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    blank_lz = 0;
    restart(16'h1234, 4'b0000);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL back_to_back t=%0d: got %h expected %h", c, obs, exp_vec()); end
      if (c == 14 || c == 26 || c == 44) begin
        logic [3:0] want;
        want = (c == 14) ? 4'h2 : 4'h3;
        tests++;
        if (nibble_out !== want) begin fails++; $display("FAIL back_to_back_nib t=%0d: got %h expected %h", c, nibble_out, want); end
      end
      load = 0;
      case (c)
        2: begin load = 1; data_in = 16'h1111; end
        3: begin load = 1; data_in = 16'h2222; end
        4: begin load = 1; data_in = 16'h3333; end
        default: ;
      endcase
    end
    load = 0;
  endtask

  task automatic test_random();
    logic [15:0] mask;
    blank_lz = 1'($urandom);
    restart(16'($urandom), 4'($urandom));
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL random cycle=%0d: got %h expected %h", c, obs, exp_vec()); end
      load = ($urandom_range(0, 29) == 0) || (m_fd && ($urandom_range(0, 1) == 0));
      if (load) begin
        case ($urandom_range(0, 3))
          0: mask = 16'hFFFF;
          1: mask = 16'h00FF;
          2: mask = 16'h000F;
          default: mask = 16'h0000;
        endcase
        data_in = 16'($urandom) & mask;
        dp_in   = 4'($urandom);
      end
      if (ena && $urandom_range(0, 199) == 0) ena = 0;
      else if (!ena && $urandom_range(0, 4) == 0) ena = 1;
      if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
    end
    load = 0;
    ena = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_scan();
    test_double_buffer();
    test_load_boundary();
    test_leading_zeros();
    test_enable_drop();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
